// File: rtl/if_wr_burst_ctrl_pkg.sv
// Shared definitions for the write-burst controller: FSM states, interface codes and
// default burst sizes per code.
package if_wr_burst_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StConfig,
    StWait,
    StHdr,
    StBurst,
    StDone
  } state_e;

  localparam int unsigned IFCODE_IFM    = 0;
  localparam int unsigned IFCODE_OFM    = 1;
  localparam int unsigned IFCODE_PSUM   = 2;
  localparam int unsigned IFCODE_FLGOFM = 3;
  localparam int unsigned NUM_IFCODES   = 4;

  localparam int unsigned WR_SIZE_IFM    = 16;
  localparam int unsigned WR_SIZE_OFM    = 12;
  localparam int unsigned WR_SIZE_PSUM   = 10;
  localparam int unsigned WR_SIZE_FLGOFM = 6;

  function automatic logic code_known(input int unsigned code);
    return code < NUM_IFCODES;
  endfunction

  // Unknown codes fall back to the flag-OFM size.
  function automatic int unsigned wr_size_default(input int unsigned code);
    case (code)
      IFCODE_IFM:  return WR_SIZE_IFM;
      IFCODE_OFM:  return WR_SIZE_OFM;
      IFCODE_PSUM: return WR_SIZE_PSUM;
      default:     return WR_SIZE_FLGOFM;
    endcase
  endfunction

endpackage

// File: rtl/if_wr_burst_ctrl_if.sv
// Config, upstream-channel and readout-FIFO signals of the write-burst controller.
interface if_wr_burst_ctrl_if #(
    parameter int unsigned SPI_WIDTH  = 32,
    parameter int unsigned TX_WIDTH   = 20,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CODE_WIDTH = 4
);
    logic                        config_ready;
    logic                        config_paulse;
    logic [CODE_WIDTH-1:0]       config_data;
    logic [TX_WIDTH-1:0]         config_size;
    logic                        config_req;
    logic                        link_active;
    logic [NUM_CH-1:0]           ch_req;
    logic [NUM_CH*SPI_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]           ch_ready;
    logic                        fifo_wr_en;
    logic [SPI_WIDTH-1:0]        fifo_din;
    logic                        fifo_full_lvl;
    logic                        burst_done;
    logic [1:0]                  err_sticky;

    modport master (
        output config_ready, config_req, ch_ready, fifo_wr_en, fifo_din, burst_done, err_sticky,
        input  config_paulse, config_data, config_size, link_active, ch_req, ch_data,
               fifo_full_lvl
    );

    modport slave (
        input  config_ready, config_req, ch_ready, fifo_wr_en, fifo_din, burst_done, err_sticky,
        output config_paulse, config_data, config_size, link_active, ch_req, ch_data,
               fifo_full_lvl
    );
endinterface

// File: rtl/if_wr_burst_ctrl_skid_buf.sv
// Ring-buffer skid: holds words that arrive after ready drops and replays them in order.
// Pop wins over push when both happen at capacity, so a full buffer can still stream.
module if_wr_burst_ctrl_skid_buf #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] dout_o,
    output logic             empty_o,
    output logic             ovf_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             full, do_pop, do_push;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == CntW'(Depth));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign ovf_o   = push_i && !do_push;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/if_wr_burst_ctrl.sv
// Write-burst controller: picks one upstream channel per config pulse, optionally writes a
// header, then moves the burst into the readout FIFO with a skid buffer behind ready.
module if_wr_burst_ctrl
    import if_wr_burst_ctrl_pkg::*;
#(
    parameter int unsigned SPI_WIDTH  = 32,
    parameter int unsigned TX_WIDTH   = 20,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CODE_WIDTH = 4,
    parameter int unsigned SKID_DEPTH = 2,
    parameter bit          HDR_EN     = 1'b1
) (
    input logic                clk_chip_i,
    input logic                reset_chip_i,
    if_wr_burst_ctrl_if.master bus_io
);
    localparam int unsigned SelW = $clog2(NUM_CH);
    localparam int unsigned PadW = SPI_WIDTH - CODE_WIDTH - TX_WIDTH;

    state_e                state_q;
    logic [SelW-1:0]       sel_q;
    logic [CODE_WIDTH-1:0] code_q;
    logic [TX_WIDTH-1:0]   size_q, out_cnt_q, acc_cnt_q;
    logic [SKID_DEPTH-1:0] rdy_hist_q;
    logic                  config_req_q, burst_done_q;
    logic [1:0]            err_q;

    logic                  in_burst, acc_room, rdy, win, accept, direct, push, pop, hdr_wr;
    logic                  skid_empty, skid_ovf;
    logic [SPI_WIDTH-1:0]  data_sel, skid_dout, header;
    logic [TX_WIDTH-1:0]   cfg_size;
    logic [SelW-1:0]       cfg_sel;

    always_comb begin
        cfg_size = bus_io.config_size;
        if (cfg_size == '0) cfg_size = TX_WIDTH'(wr_size_default(32'(bus_io.config_data)));
        cfg_sel = code_known(32'(bus_io.config_data)) ? bus_io.config_data[SelW-1:0] : '0;
    end

    assign in_burst = (state_q == StBurst);
    assign acc_room = (acc_cnt_q < size_q);
    assign rdy      = in_burst && !bus_io.fifo_full_lvl && skid_empty && acc_room;
    // Late words are honoured for SKID_DEPTH cycles after ready falls: the upstream latency.
    assign win      = rdy || (|rdy_hist_q);
    assign data_sel = bus_io.ch_data[sel_q*SPI_WIDTH +: SPI_WIDTH];
    assign accept   = in_burst && bus_io.ch_req[sel_q] && win && acc_room;
    assign pop      = in_burst && !skid_empty && !bus_io.fifo_full_lvl;
    assign direct   = accept && !bus_io.fifo_full_lvl && skid_empty;
    assign push     = accept && !direct;
    assign hdr_wr   = (state_q == StHdr) && !bus_io.fifo_full_lvl;
    assign header   = {code_q, {PadW{1'b0}}, size_q};

    always_comb begin
        bus_io.fifo_wr_en = hdr_wr || pop || direct;
        bus_io.fifo_din   = '0;
        if (hdr_wr)      bus_io.fifo_din = header;
        else if (pop)    bus_io.fifo_din = skid_dout;
        else if (direct) bus_io.fifo_din = data_sel;
    end

    always_comb begin
        bus_io.ch_ready        = '0;
        bus_io.ch_ready[sel_q] = rdy;
    end

    assign bus_io.config_ready = (state_q == StIdle);
    assign bus_io.config_req   = config_req_q;
    assign bus_io.burst_done   = burst_done_q;
    assign bus_io.err_sticky   = err_q;

    if_wr_burst_ctrl_skid_buf #(
        .Depth (SKID_DEPTH),
        .Width (SPI_WIDTH)
    ) u_skid (
        .clk_i   (clk_chip_i),
        .rst_i   (reset_chip_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (data_sel),
        .dout_o  (skid_dout),
        .empty_o (skid_empty),
        .ovf_o   (skid_ovf)
    );

    always_ff @(posedge clk_chip_i or posedge reset_chip_i) begin
        if (reset_chip_i) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            code_q       <= '0;
            size_q       <= '0;
            out_cnt_q    <= '0;
            acc_cnt_q    <= '0;
            rdy_hist_q   <= '0;
            config_req_q <= 1'b0;
            burst_done_q <= 1'b0;
            err_q        <= '0;
        end else begin
            burst_done_q <= 1'b0;
            rdy_hist_q   <= (rdy_hist_q << 1) | SKID_DEPTH'(rdy);
            if (accept) acc_cnt_q <= acc_cnt_q + 1'b1;
            if ((pop || direct) && (out_cnt_q != size_q)) out_cnt_q <= out_cnt_q + 1'b1;
            if (bus_io.config_paulse && (state_q != StIdle)) err_q[0] <= 1'b1;
            if (skid_ovf) err_q[1] <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (bus_io.config_paulse) begin
                        sel_q   <= cfg_sel;
                        code_q  <= bus_io.config_data;
                        size_q  <= cfg_size;
                        state_q <= StConfig;
                    end
                end
                StConfig: begin
                    config_req_q <= 1'b1;
                    acc_cnt_q    <= '0;
                    out_cnt_q    <= '0;
                    state_q      <= StWait;
                end
                StWait: begin
                    if (bus_io.link_active) begin
                        state_q <= HDR_EN ? StHdr : StBurst;
                        if (!HDR_EN) config_req_q <= 1'b0;
                    end
                end
                StHdr: begin
                    if (!bus_io.fifo_full_lvl) begin
                        state_q      <= StBurst;
                        config_req_q <= 1'b0;
                    end
                end
                StBurst: begin
                    if (out_cnt_q == size_q) state_q <= StDone;
                end
                StDone: begin
                    if (!bus_io.link_active) begin
                        state_q      <= StIdle;
                        burst_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_if_wr_burst_ctrl.sv
// Directed bench for the write-burst controller with a scoreboard of expected FIFO words.
module tb_if_wr_burst_ctrl;
    import if_wr_burst_ctrl_pkg::*;

    localparam int unsigned SPI_W = 32;
    localparam int unsigned TX_W  = 20;
    localparam int unsigned NCH   = 4;
    localparam int unsigned CW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_wr_burst_ctrl_if #(
        .SPI_WIDTH  (SPI_W),
        .TX_WIDTH   (TX_W),
        .NUM_CH     (NCH),
        .CODE_WIDTH (CW)
    ) bus ();

    if_wr_burst_ctrl #(
        .SPI_WIDTH  (SPI_W),
        .TX_WIDTH   (TX_W),
        .NUM_CH     (NCH),
        .CODE_WIDTH (CW),
        .SKID_DEPTH (2),
        .HDR_EN     (1'b1)
    ) dut (
        .clk_chip_i   (clk),
        .reset_chip_i (rst),
        .bus_io       (bus)
    );

    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] exp_q[$];
    int          wr_total = 0;
    int          done_cnt = 0;
    int          up_burst = 0;
    int          up_sel   = 0;
    bit          up_hold  = 1'b0;

    function automatic logic [31:0] up_word(input int b, input int ch, input int idx);
        return {b[7:0], ch[3:0], idx[19:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Upstream source: keeps presenting for two cycles after ready falls, advancing on each
    // cycle it considers a transfer; in hold mode it asserts req permanently.
    initial begin
        bit   h1, h2, prev_go, win;
        logic rn;
        int   idx, last_burst;
        h1 = 0; h2 = 0; prev_go = 0; idx = 0; last_burst = 0;
        bus.ch_req  = '0;
        bus.ch_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (up_burst != last_burst) begin
                last_burst = up_burst;
                idx        = 0;
            end else if (prev_go) begin
                idx++;
            end
            rn  = bus.ch_ready[up_sel];
            win = (rn === 1'b1) || h1 || h2;
            for (int c = 0; c < NCH; c++) begin
                bus.ch_req[c]           = 1'b1;
                bus.ch_data[c*32 +: 32] = {8'hEE, c[3:0], 20'h00BAD};
            end
            bus.ch_req[up_sel]           = up_hold || win;
            bus.ch_data[up_sel*32 +: 32] = up_word(up_burst, up_sel, idx);
            prev_go = win;
            h2      = h1;
            h1      = (rn === 1'b1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.fifo_wr_en === 1'b1) begin
                wr_total++;
                check("sb_avail", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("fifo_din", bus.fifo_din, exp_q.pop_front());
            end
            if (bus.burst_done === 1'b1) done_cnt++;
            if (bus.ch_ready != '0) check("ch_ready_sel", 32'(bus.ch_ready), 32'(1 << up_sel));
        end
    end

    task automatic check_reset(input string t);
        check({t, "_cfg_ready"}, 32'(bus.config_ready), 1);
        check({t, "_cfg_req"}, 32'(bus.config_req), 0);
        check({t, "_ch_ready"}, 32'(bus.ch_ready), 0);
        check({t, "_wr_en"}, 32'(bus.fifo_wr_en), 0);
        check({t, "_din"}, bus.fifo_din, 0);
        check({t, "_done"}, 32'(bus.burst_done), 0);
        check({t, "_err"}, 32'(bus.err_sticky), 0);
    endtask

    int wr_base;

    task automatic start_burst(input logic [3:0] code, input int sz_in, input int sz_exp,
                               input int sel);
        up_burst++;
        up_sel  = sel;
        wr_base = wr_total;
        exp_q.push_back({code, 8'h00, sz_exp[19:0]});
        for (int k = 0; k < sz_exp; k++) exp_q.push_back(up_word(up_burst, sel, k));
        bus.config_data   = code;
        bus.config_size   = sz_in[19:0];
        bus.config_paulse = 1'b1;
        step();
        bus.config_paulse = 1'b0;
        step();
        check("cfg_req_set", 32'(bus.config_req), 1);
        check("cfg_ready_low", 32'(bus.config_ready), 0);
        step();
        bus.link_active = 1'b1;
    endtask

    task automatic wait_writes(input int n, input string tag);
        for (int i = 0; i < 200 && (wr_total - wr_base) < n; i++) step();
        check(tag, 32'((wr_total - wr_base) >= n), 1);
    endtask

    task automatic finish_burst(input int sz);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) step();
        bus.link_active = 1'b0;
        for (int i = 0; i < 10 && done_cnt == d0; i++) step();
        repeat (3) step();
        check("burst_done_once", done_cnt - d0, 1);
        check("wr_count", wr_total - wr_base, sz + 1);
        check("idle_ready", 32'(bus.config_ready), 1);
        check("req_clear", 32'(bus.config_req), 0);
    endtask

    initial begin
        bus.config_paulse = 1'b0;
        bus.config_data   = '0;
        bus.config_size   = '0;
        bus.link_active   = 1'b0;
        bus.fifo_full_lvl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;
        step();

        // OFM with default size and header, FIFO never full.
        start_burst(4'(IFCODE_OFM), 0, WR_SIZE_OFM, 1);
        finish_burst(WR_SIZE_OFM);

        // FIFO almost-full for 5 cycles after payload word 3; late words go through the skid.
        start_burst(4'(IFCODE_IFM), 8, 8, 0);
        wait_writes(4, "t2_word3");
        bus.fifo_full_lvl = 1'b1;
        repeat (5) step();
        bus.fifo_full_lvl = 1'b0;
        finish_burst(8);
        check("t2_err", 32'(bus.err_sticky), 0);

        // Upstream holds req past the burst size.
        up_hold = 1'b1;
        start_burst(4'(IFCODE_PSUM), 5, 5, 2);
        finish_burst(5);
        up_hold = 1'b0;
        check("t3_err", 32'(bus.err_sticky), 0);

        // Stray config pulse mid-burst, then a legitimate one from IDLE.
        start_burst(4'(IFCODE_OFM), 4, 4, 1);
        wait_writes(2, "t4_word1");
        bus.config_data   = 4'(IFCODE_PSUM);
        bus.config_size   = 20'd3;
        bus.config_paulse = 1'b1;
        step();
        bus.config_paulse = 1'b0;
        check("t4_err_set", 32'(bus.err_sticky), 1);
        finish_burst(4);
        check("t4_err_hold", 32'(bus.err_sticky), 1);
        start_burst(4'(IFCODE_IFM), 3, 3, 0);
        finish_burst(3);

        // Reset in the middle of a burst, then a clean 8-word burst.
        start_burst(4'(IFCODE_IFM), 8, 8, 0);
        wait_writes(5, "t5_word4");
        rst = 1'b1;
        #1;
        check_reset("t5");
        exp_q.delete();
        bus.link_active = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        start_burst(4'(IFCODE_IFM), 8, 8, 0);
        finish_burst(8);

        // Unknown code: channel 0, flag-OFM default size, raw code in the header.
        start_burst(4'hF, 0, WR_SIZE_FLGOFM, 0);
        finish_burst(WR_SIZE_FLGOFM);
        check("t6_err", 32'(bus.err_sticky), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
